conv_result_collector: RTL

Downstream stage of the serial 1-D convolution engine. Captures each frame of L = M+N-1 8-bit convolution results as it is produced, ping-pong buffers it, and replays it on a valid/ready stream with a last marker. Decouples the free-running, non-stallable convolution output from consumers that apply backpressure. Optionally reports the peak value and index of each frame.

---
 rtl/conv_result_collector_if.sv | 29 ++
 rtl/conv_result_collector.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_collector_if.sv
// conv_result_collector_if: groups the capture stream, replay stream and status
// outputs of the convolution result collector.
// Ports: in_valid/in_data (producer -> collector), out_valid/out_ready/out_data/
//        out_last (collector <-> consumer), peak_val/peak_idx/frame_cnt/ovf (status).
// master = environment side (drives input stream and out_ready), slave = collector.
interface conv_result_collector_if #(
   parameter int IW = 4
);
   logic          in_valid;
   logic [7:0]    in_data;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_data;
   logic          out_last;
   logic [7:0]    peak_val;
   logic [IW-1:0] peak_idx;
   logic [7:0]    frame_cnt;
   logic          ovf;

   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data, out_last, peak_val, peak_idx, frame_cnt, ovf
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data, out_last, peak_val, peak_idx, frame_cnt, ovf
   );
endinterface

// File: rtl/conv_result_collector.sv
// conv_result_collector: captures frames of L=M+N-1 convolution bytes into two
//    ping-pong banks and replays each frame on a valid/ready stream with out_last.
// Latency: final input byte at edge k -> out_valid high after edge k+1.
// Backpressure: input cannot stall; when the next bank is still full, incoming
//    bytes are dropped (ovf sticky) until that bank drains. Output holds while !out_ready.
// Ports: clk, rst (synchronous, active low) plus bus (conv_result_collector_if.slave).
// Optional feature macro: CONV_COLLECT_PEAK_EN (per-frame peak value/index tracking);
//    when undefined, peak_val/peak_idx are tied to 0.
module conv_result_collector #(
   parameter int M  = 6,
   parameter int N  = 5,
   parameter int IW = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   conv_result_collector_if.slave  bus
);
   localparam int            L        = M + N - 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(L - 1);

   typedef enum logic {W_FILL, W_BLOCKED} w_state_e;
   typedef enum logic {R_IDLE, R_DRAIN}   r_state_e;

   // Frame storage; contents are deliberately not reset, the full flags gate use.
   logic [7:0]    mem_q [2][L];

   // Write side
   w_state_e      w_state_q, w_state_d;
   logic          w_sel_q,   w_sel_d;
   logic [IW-1:0] w_idx_q,   w_idx_d;
   logic          wr_en;
   logic [1:0]    full_set;

   // Shared bank status
   logic [1:0]    full_q,    full_d;
   logic [1:0]    full_clr;
   logic          ovf_q,     ovf_d;

   // Read side
   r_state_e      r_state_q, r_state_d;
   logic          r_sel_q,   r_sel_d;
   logic [IW-1:0] r_idx_q,   r_idx_d;
   logic [IW-1:0] r_idx_nxt;
   logic          out_valid_q, out_valid_d;
   logic [7:0]    out_data_q,  out_data_d;
   logic          out_last_q,  out_last_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;

   // ------------------------------------------------------------------
   // Read side: R_IDLE waits for the selected bank to fill, R_DRAIN
   // replays it one beat per handshake.
   // ------------------------------------------------------------------
   always_comb begin
      r_state_d   = r_state_q;
      r_sel_d     = r_sel_q;
      r_idx_d     = r_idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      frame_cnt_d = frame_cnt_q;
      full_clr    = 2'b00;
      r_idx_nxt   = r_idx_q + IW'(1);

      case (r_state_q)
         R_IDLE: begin
            if (full_q[r_sel_q]) begin
               r_state_d   = R_DRAIN;
               r_idx_d     = '0;
               out_valid_d = 1'b1;
               out_data_d  = mem_q[r_sel_q][0];
               out_last_d  = (LAST_IDX == '0);
            end
         end
         R_DRAIN: begin
            if (bus.out_ready) begin
               if (r_idx_q == LAST_IDX) begin
                  // Final beat accepted: release the bank to the write side.
                  full_clr[r_sel_q] = 1'b1;
                  r_sel_d           = ~r_sel_q;
                  r_idx_d           = '0;
                  frame_cnt_d       = frame_cnt_q + 8'd1;
                  out_valid_d       = 1'b0;
                  out_last_d        = 1'b0;
                  r_state_d         = R_IDLE;
               end else begin
                  r_idx_d    = r_idx_nxt;
                  out_data_d = mem_q[r_sel_q][r_idx_nxt];
                  out_last_d = (r_idx_nxt == LAST_IDX);
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Write side: W_FILL stores bytes; W_BLOCKED drops them while the bank
   // it is pointing at still awaits draining.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_d = w_state_q;
      w_sel_d   = w_sel_q;
      w_idx_d   = w_idx_q;
      wr_en     = 1'b0;
      full_set  = 2'b00;
      ovf_d     = ovf_q;

      case (w_state_q)
         W_FILL: begin
            if (bus.in_valid) begin
               wr_en = 1'b1;
               if (w_idx_q == LAST_IDX) begin
                  full_set[w_sel_q] = 1'b1;
                  w_sel_d           = ~w_sel_q;
                  w_idx_d           = '0;
                  // A bank whose drain completes this same cycle counts as free.
                  if (full_q[~w_sel_q] && !full_clr[~w_sel_q]) begin
                     w_state_d = W_BLOCKED;
                  end
               end else begin
                  w_idx_d = w_idx_q + IW'(1);
               end
            end
         end
         W_BLOCKED: begin
            // Flag is sampled before the edge, so a byte arriving in the
            // clearing cycle is still dropped; writing resumes next cycle.
            if (bus.in_valid) begin
               ovf_d = 1'b1;
            end
            if (!full_q[w_sel_q] || full_clr[w_sel_q]) begin
               w_state_d = W_FILL;
            end
         end
         default: w_state_d = W_FILL;
      endcase
   end

   // Set and clear never target the same bank: the writer only fills empty banks.
   assign full_d = (full_q | full_set) & ~full_clr;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[w_sel_q][w_idx_q] <= bus.in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         w_state_q   <= W_FILL;
         w_sel_q     <= 1'b0;
         w_idx_q     <= '0;
         full_q      <= 2'b00;
         ovf_q       <= 1'b0;
         r_state_q   <= R_IDLE;
         r_sel_q     <= 1'b0;
         r_idx_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'd0;
         out_last_q  <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else begin
         w_state_q   <= w_state_d;
         w_sel_q     <= w_sel_d;
         w_idx_q     <= w_idx_d;
         full_q      <= full_d;
         ovf_q       <= ovf_d;
         r_state_q   <= r_state_d;
         r_sel_q     <= r_sel_d;
         r_idx_q     <= r_idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.frame_cnt = frame_cnt_q;
   assign bus.ovf       = ovf_q;

`ifdef CONV_COLLECT_PEAK_EN
   // ------------------------------------------------------------------
   // Peak tracking: running max over the frame being filled, latched into
   // the bank's peak registers together with the final byte.
   // ------------------------------------------------------------------
   logic [7:0]    run_max_q, run_max_d;
   logic [IW-1:0] run_idx_q, run_idx_d;
   logic [7:0]    pk_val_q [2];
   logic [7:0]    pk_val_d [2];
   logic [IW-1:0] pk_idx_q [2];
   logic [IW-1:0] pk_idx_d [2];
   logic [7:0]    cand_max;
   logic [IW-1:0] cand_idx;
   logic [7:0]    peak_val_q, peak_val_d;
   logic [IW-1:0] peak_idx_q, peak_idx_d;
   logic          load_pk;

   always_comb begin
      // Index 0 always seeds the max; later bytes must be strictly greater
      // so the first occurrence of the peak keeps its index.
      cand_max = run_max_q;
      cand_idx = run_idx_q;
      if ((w_idx_q == '0) || (bus.in_data > run_max_q)) begin
         cand_max = bus.in_data;
         cand_idx = w_idx_q;
      end

      run_max_d = run_max_q;
      run_idx_d = run_idx_q;
      pk_val_d  = pk_val_q;
      pk_idx_d  = pk_idx_q;
      if (wr_en) begin
         run_max_d = cand_max;
         run_idx_d = cand_idx;
         if (w_idx_q == LAST_IDX) begin
            pk_val_d[w_sel_q] = cand_max;
            pk_idx_d[w_sel_q] = cand_idx;
         end
      end
   end

   // Presented peak follows the frame being drained, loaded with beat 0.
   assign load_pk = (r_state_q == R_IDLE) && full_q[r_sel_q];

   always_comb begin
      peak_val_d = peak_val_q;
      peak_idx_d = peak_idx_q;
      if (load_pk) begin
         peak_val_d = pk_val_q[r_sel_q];
         peak_idx_d = pk_idx_q[r_sel_q];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         run_max_q  <= 8'd0;
         run_idx_q  <= '0;
         pk_val_q   <= '{default: 8'd0};
         pk_idx_q   <= '{default: '0};
         peak_val_q <= 8'd0;
         peak_idx_q <= '0;
      end else begin
         run_max_q  <= run_max_d;
         run_idx_q  <= run_idx_d;
         pk_val_q   <= pk_val_d;
         pk_idx_q   <= pk_idx_d;
         peak_val_q <= peak_val_d;
         peak_idx_q <= peak_idx_d;
      end
   end

   assign bus.peak_val = peak_val_q;
   assign bus.peak_idx = peak_idx_q;
`else
   assign bus.peak_val = 8'd0;
   assign bus.peak_idx = '0;
`endif

endmodule
